// File: rtl/survivor_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : survivor_mem_pkg                                                 |
// | Purpose : Shared Viterbi decoder constants, the survivor-memory FSM state  |
// |           enum and a modulo-D pointer increment helper. Imported by the    |
// |           ACS array, the survivor memory and the traceback unit.           |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package survivor_mem_pkg;

   localparam int K    = 7;                  // constraint length
   localparam int M    = K - 1;              // state bits
   localparam int D    = 40;                 // traceback depth = buffer rows
   localparam int NS   = 1 << M;             // states per trellis step
   localparam int HOLD = 2;                  // post-write lockout cycles
   localparam int TW   = $clog2(D);          // row pointer width
   localparam int CW   = $clog2(D + 1);      // fill counter width
   localparam int LW   = $clog2(HOLD + 1);   // lockout counter width

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,   // initial fill, one row per cycle
      ST_IDLE = 2'd1,   // streaming, waiting for a row while traceback idle
      ST_HOLD = 2'd2,   // lockout while traceback busy flag propagates
      ST_WAIT = 2'd3    // waiting for traceback to finish
   } state_e;

   // D need not be a power of two, so the pointer wraps explicitly.
   function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
      return (p == TW'(D - 1)) ? '0 : p + TW'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/survivor_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : survivor_mem_if                                                  |
// | Purpose : Bundles the ACS handshake, traceback status/read address and the |
// |           survivor memory outputs.                                         |
// | Ports   : master = ACS + traceback side (drives row, busy, read address)   |
// |           slave  = survivor memory (drives ready, pointers, read bit)      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface survivor_mem_if;
   import survivor_mem_pkg::*;

   logic            acs_valid;
   logic            acs_ready;
   logic [NS-1:0]   acs_dec;
   logic [M-1:0]    acs_best;
   logic            tb_busy;
   logic [TW-1:0]   wr_ptr;
   logic [M-1:0]    s_end;
   logic            filled;
   logic [TW-1:0]   tb_time;
   logic [M-1:0]    tb_state;
   logic            tb_surv_bit;

   modport master (
      output acs_valid, acs_dec, acs_best, tb_busy, tb_time, tb_state,
      input  acs_ready, wr_ptr, s_end, filled, tb_surv_bit
   );

   modport slave (
      input  acs_valid, acs_dec, acs_best, tb_busy, tb_time, tb_state,
      output acs_ready, wr_ptr, s_end, filled, tb_surv_bit
   );

endinterface
`default_nettype wire

// File: rtl/survivor_mem_surv_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : surv_ram                                                         |
// | Purpose : Simple dual-port D x NS decision array. One full row written per |
// |           cycle, one registered bit read per cycle.                        |
// | Ports   : clk, rst          clock, synchronous active-high reset           |
// |           we_i/waddr_i/wdata_i   row write port                           |
// |           raddr_i/rcol_i    bit read address (row, column)                 |
// |           rbit_o            registered read bit, one cycle after address   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module surv_ram
   import survivor_mem_pkg::*;
(
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            we_i,
   input  wire logic [TW-1:0]   waddr_i,
   input  wire logic [NS-1:0]   wdata_i,
   input  wire logic [TW-1:0]   raddr_i,
   input  wire logic [M-1:0]    rcol_i,
   output      logic            rbit_o
);

   // Contents are deliberately not reset; rows are stale until written.
   logic [NS-1:0] mem_q [D];
   logic          rbit_q;

   always_ff @(posedge clk) begin
      if (we_i && (waddr_i < TW'(D))) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Non-blocking read of mem_q gives the pre-write row on a same-row
   // collision. Rows beyond the buffer depth read as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rbit_q <= 1'b0;
      end else if (raddr_i < TW'(D)) begin
         rbit_q <= mem_q[raddr_i][rcol_i];
      end else begin
         rbit_q <= 1'b0;
      end
   end

   assign rbit_o = rbit_q;

endmodule
`default_nettype wire

// File: rtl/survivor_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : survivor_mem                                                     |
// | Purpose : Survivor-decision memory between the ACS array and traceback.    |
// |           Stores one decision row per trellis step in a D-deep circular    |
// |           buffer, publishes the write pointer and end state, answers       |
// |           single-bit survivor reads and throttles the ACS so exactly one   |
// |           row is accepted per traceback once the buffer is full.           |
// | Ports   : clk, rst   clock, synchronous active-high reset                  |
// |           sm_if      survivor_mem_if.slave (ACS handshake, traceback       |
// |                      status, write pointer, end state, read port)          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module survivor_mem
   import survivor_mem_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst,
   survivor_mem_if.slave   sm_if
);

   state_e          state_q, state_d;
   logic [LW-1:0]   lock_q, lock_d;
   logic [TW-1:0]   wr_ptr_q;
   logic [M-1:0]    s_end_q;
   logic [CW-1:0]   fill_q;
   logic            ready;
   logic            accept;
   logic            we;

   // Next-state logic. Transitions out of FILL/IDLE look at acs_valid
   // directly rather than at accept, so ready never feeds back into itself.
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      ready   = 1'b0;
      unique case (state_q)
         ST_FILL: begin
            ready = 1'b1;
            if (sm_if.acs_valid && (fill_q == CW'(D - 1))) begin
               state_d = ST_HOLD;
               lock_d  = LW'(HOLD);
            end
         end
         ST_IDLE: begin
            ready = !sm_if.tb_busy;
            if (sm_if.acs_valid && !sm_if.tb_busy) begin
               state_d = ST_HOLD;
               lock_d  = LW'(HOLD);
            end
         end
         ST_HOLD: begin
            // Lockout covers the registered busy flag inside traceback:
            // busy cannot be trusted until HOLD cycles after the write.
            if (lock_q > LW'(1)) begin
               lock_d = lock_q - LW'(1);
            end else begin
               lock_d  = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!sm_if.tb_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_FILL;
            lock_d  = '0;
         end
      endcase
   end

   assign accept = sm_if.acs_valid && ready;
   assign we     = accept && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FILL;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         s_end_q  <= '0;
         fill_q   <= '0;
      end else if (accept) begin
         wr_ptr_q <= ptr_inc(wr_ptr_q);
         s_end_q  <= sm_if.acs_best;
         if (fill_q != CW'(D)) begin
            fill_q <= fill_q + CW'(1);
         end
      end
   end

   surv_ram u_surv_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (sm_if.acs_dec),
      .raddr_i (sm_if.tb_time),
      .rcol_i  (sm_if.tb_state),
      .rbit_o  (sm_if.tb_surv_bit)
   );

   assign sm_if.acs_ready = ready;
   assign sm_if.wr_ptr    = wr_ptr_q;
   assign sm_if.s_end     = s_end_q;
   assign sm_if.filled    = (fill_q == CW'(D));

endmodule
`default_nettype wire

// File: tb/tb_survivor_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_survivor_mem                                                  |
// | Purpose : Self-checking bench for survivor_mem: behavioural model of the   |
// |           buffer, pointers and throttle, checked every cycle, plus literal |
// |           expectations for reset, fill, reads, throttle gap, mid-stream    |
// |           reset and read/write collision, then a randomized phase.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_survivor_mem;
   import survivor_mem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   survivor_mem_if sm ();

   survivor_mem dut (
      .clk   (clk),
      .rst   (rst),
      .sm_if (sm.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit [NS-1:0] m_mem [D];
   bit          m_known [D];
   int          m_wp, m_send, m_fill, m_lock;
   bit          m_wait;
   bit          m_surv, m_surv_known;
   bit          m_started = 1'b0;
   int          cyc = 0;
   int          m_last_acc = -1000;
   int          dut_acc_edge = -1000;

   // Ready: always during the initial fill; otherwise only after the
   // lockout has expired and traceback has been seen idle, then !busy.
   function automatic bit mdl_ready();
      if (m_fill < D) return 1'b1;
      if (m_lock > 0 || m_wait) return 1'b0;
      return !sm.tb_busy;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_wp         <= 0;
         m_send       <= 0;
         m_fill       <= 0;
         m_lock       <= 0;
         m_wait       <= 1'b0;
         m_surv       <= 1'b0;
         m_surv_known <= 1'b1;
         m_started    <= 1'b1;
      end else begin
         if (int'(sm.tb_time) >= D) begin
            m_surv       <= 1'b0;
            m_surv_known <= 1'b1;
         end else begin
            m_surv       <= m_mem[sm.tb_time][sm.tb_state];
            m_surv_known <= m_known[sm.tb_time];
         end
         if (sm.acs_valid && mdl_ready()) begin
            m_mem[m_wp]   <= sm.acs_dec;
            m_known[m_wp] <= 1'b1;
            m_wp          <= (m_wp + 1) % D;
            m_send        <= int'(sm.acs_best);
            m_last_acc    <= cyc + 1;
            if (m_fill < D) m_fill <= m_fill + 1;
         end
         if (m_fill < D) begin
            if (sm.acs_valid && m_fill == D - 1) begin
               m_lock <= HOLD;
               m_wait <= 1'b1;
            end
         end else if (m_lock > 0) begin
            m_lock <= m_lock - 1;
         end else if (m_wait) begin
            if (!sm.tb_busy) m_wait <= 1'b0;
         end else if (sm.acs_valid && !sm.tb_busy) begin
            m_lock <= HOLD;
            m_wait <= 1'b1;
         end
      end
   end

   // Compare process: every cycle after the first reset edge.
   always @(negedge clk) begin
      if (m_started) begin
         chk("wr_ptr", 64'(sm.wr_ptr), 64'(m_wp));
         chk("s_end", 64'(sm.s_end), 64'(m_send));
         chk("filled", 64'(sm.filled), 64'(m_fill == D));
         chk("acs_ready", 64'(sm.acs_ready), 64'(mdl_ready()));
         if (m_surv_known) chk("tb_surv_bit", 64'(sm.tb_surv_bit), 64'(m_surv));
         if (sm.acs_valid && sm.acs_ready && !rst) dut_acc_edge <= cyc + 1;
      end
   end

   // ---------------- stimulus ----------------
   bit auto_busy  = 1'b0;
   int auto_start = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Traceback stand-in: busy from 2 edges after an accept for 41 edges.
   task automatic set_busy();
      int n;
      n = cyc + 1;
      if (auto_busy && m_last_acc > auto_start)
         sm.tb_busy = (n >= m_last_acc + 2) && (n <= m_last_acc + 42);
      else
         sm.tb_busy = 1'b0;
   endtask

   initial begin
      int  prev_acc;
      int  n_stream;
      bit  reached;

      rst          = 1'b1;
      sm.acs_valid = 1'b0;
      sm.acs_dec   = '0;
      sm.acs_best  = '0;
      sm.tb_busy   = 1'b0;
      sm.tb_time   = '0;
      sm.tb_state  = '0;
      tick();
      tick();
      chk("rst_wr_ptr", 64'(sm.wr_ptr), 64'd0);
      chk("rst_s_end", 64'(sm.s_end), 64'd0);
      chk("rst_filled", 64'(sm.filled), 64'd0);
      chk("rst_surv", 64'(sm.tb_surv_bit), 64'd0);
      chk("rst_ready", 64'(sm.acs_ready), 64'd1);
      rst = 1'b0;

      // Fill: row i holds a single 1 at bit i.
      for (int i = 0; i < D; i++) begin
         sm.acs_valid = 1'b1;
         sm.acs_dec   = NS'(64'd1 << (i % 64));
         sm.acs_best  = M'(i % 64);
         tick();
         if (i == D - 2) begin
            chk("fill39_wr_ptr", 64'(sm.wr_ptr), 64'd39);
            chk("fill39_filled", 64'(sm.filled), 64'd0);
         end
      end
      chk("fill_wr_ptr_wrap", 64'(sm.wr_ptr), 64'd0);
      chk("fill_filled", 64'(sm.filled), 64'd1);
      chk("fill_s_end", 64'(sm.s_end), 64'd39);
      chk("fill_hold_ready", 64'(sm.acs_ready), 64'd0);

      sm.acs_valid = 1'b0;
      sm.tb_time   = TW'(5);
      sm.tb_state  = M'(5);
      tick();
      chk("read_r5_s5", 64'(sm.tb_surv_bit), 64'd1);
      sm.tb_state  = M'(2);
      tick();
      chk("read_r5_s2", 64'(sm.tb_surv_bit), 64'd0);
      sm.tb_time   = TW'(45);
      tick();
      chk("read_r45", 64'(sm.tb_surv_bit), 64'd0);

      // Throttle: valid held high, one accept per traceback.
      auto_busy    = 1'b1;
      auto_start   = cyc;
      sm.acs_valid = 1'b1;
      sm.acs_dec   = '0;
      prev_acc     = dut_acc_edge;
      n_stream     = 0;
      reached      = 1'b0;
      for (int c = 0; c < 2000 && !reached; c++) begin
         sm.tb_time  = TW'($urandom_range(0, D - 1));
         sm.tb_state = M'($urandom_range(0, NS - 1));
         sm.acs_best = M'($urandom_range(0, NS - 1));
         set_busy();
         tick();
         if (dut_acc_edge != prev_acc) begin
            if (n_stream > 0) chk("stream_gap", 64'(dut_acc_edge - prev_acc), 64'd44);
            n_stream++;
            prev_acc = dut_acc_edge;
         end
         if (m_wp == 17 && m_wait && m_lock == 0 && sm.tb_busy) reached = 1'b1;
      end
      chk("throttle_reached_wait17", 64'(reached), 64'd1);

      // Mid-stream reset while waiting on traceback.
      rst          = 1'b1;
      auto_busy    = 1'b0;
      sm.tb_busy   = 1'b0;
      sm.acs_valid = 1'b0;
      tick();
      chk("mid_rst_wr_ptr", 64'(sm.wr_ptr), 64'd0);
      chk("mid_rst_filled", 64'(sm.filled), 64'd0);
      chk("mid_rst_ready", 64'(sm.acs_ready), 64'd1);
      chk("mid_rst_s_end", 64'(sm.s_end), 64'd0);
      chk("mid_rst_surv", 64'(sm.tb_surv_bit), 64'd0);
      rst = 1'b0;

      // Collision: row 7 held zeros from the throttle phase.
      for (int i = 0; i < 7; i++) begin
         sm.acs_valid = 1'b1;
         sm.acs_dec   = NS'(64'd1 << i);
         sm.acs_best  = M'(i);
         tick();
      end
      sm.acs_dec  = NS'(64'd1 << 8);
      sm.tb_time  = TW'(7);
      sm.tb_state = M'(8);
      tick();
      chk("collide_old", 64'(sm.tb_surv_bit), 64'd0);
      sm.acs_valid = 1'b0;
      tick();
      chk("collide_new", 64'(sm.tb_surv_bit), 64'd1);

      // Randomized phase.
      for (int c = 0; c < 3000; c++) begin
         sm.acs_valid = ($urandom_range(0, 3) != 0);
         sm.acs_dec   = {$urandom(), $urandom()};
         sm.acs_best  = M'($urandom_range(0, NS - 1));
         sm.tb_busy   = ($urandom_range(0, 3) == 0);
         sm.tb_time   = TW'($urandom_range(0, 47));
         sm.tb_state  = M'($urandom_range(0, NS - 1));
         rst          = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst          = 1'b0;
      sm.acs_valid = 1'b0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
